// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command responder.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DECODE,
        ST_TX,
        ST_TXGAP
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_READ,
        CMD_WRITE
    } cmd_t;

    localparam int unsigned REPLY_LEN = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned ACC_W     = 16;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_LR = 8'h72;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_LW = 8'h77;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;

    // Line parse state carried between received bytes
    typedef struct packed {
        logic             active;
        cmd_t             cmd;
        logic [CNT_W-1:0] digit_cnt;
        logic [ACC_W-1:0] acc;
        logic             err;
    } parse_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/hex_ascii.sv
// Combinational nibble-to-ASCII encode and ASCII-to-nibble decode.
module hex_ascii (
    input  logic [3:0] nibble,
    input  logic [7:0] ascii,
    output logic [7:0] ascii_c,
    output logic [3:0] nibble_c,
    output logic       valid_c
);

    // Encode a nibble as an uppercase hex character
    always_comb begin
        ascii_c = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    end

    // Decode 0-9, A-F, a-f; anything else is flagged invalid
    always_comb begin
        nibble_c = 4'h0;
        valid_c  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble_c = ascii[3:0];
            valid_c  = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) || (ascii >= 8'h61 && ascii <= 8'h66)) begin
            nibble_c = ascii[3:0] + 4'd9;
            valid_c  = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// ASCII read/write command responder between the UART FIFOs and a register bank.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [7:0]  REG_RESET = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_fifo_empty,
    input  logic [7:0]            rx_fifo_data_out,
    output logic                  rx_fifo_read_en,
    input  logic                  uart_tx_fifo_ready,
    output logic                  start_uart_tx,
    output logic [7:0]            uart_tx_data,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  reg_wr_pulse,
    output logic [7:0]            reg_wr_addr,
    output logic                  busy
);

    localparam int unsigned AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0]  NUM_REGS_9 = 9'(NUM_REGS);

    state_t     state;
    parse_t     ps;
    parse_t     ps_nxt;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] reply_buf [REPLY_LEN];
    logic       reply_hex;
    logic [1:0] tx_idx;

    logic       digit_valid;
    logic [3:0] digit_val;
    logic [7:0] hex_char;
    logic [3:0] tx_nib;
    logic [7:0] tx_byte;
    logic [7:0] exec_addr;
    logic       addr_ok;
    logic       count_ok;
    logic       line_err;
    logic [7:0] rd_val;

    // Single converter: decodes the incoming byte, encodes the outgoing reply nibble
    hex_ascii u_hex (
        .nibble   (tx_nib),
        .ascii    (rx_fifo_data_out),
        .ascii_c  (hex_char),
        .nibble_c (digit_val),
        .valid_c  (digit_valid)
    );

    // Flatten the register bank onto the output bus
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[8*gi +: 8] = regs_q[gi];
    end

    // Command execution terms evaluated when a terminator arrives
    always_comb begin
        exec_addr = (ps.cmd == CMD_WRITE) ? ps.acc[15:8] : ps.acc[7:0];
        addr_ok   = ({1'b0, exec_addr} < NUM_REGS_9);
        count_ok  = ((ps.cmd == CMD_READ)  && (ps.digit_cnt == 3'd2)) ||
                    ((ps.cmd == CMD_WRITE) && (ps.digit_cnt == 3'd4));
        line_err  = ps.err || !count_ok || !addr_ok;
        rd_val    = addr_ok ? regs_q[AW'(exec_addr)] : 8'h00;
        tx_nib    = reply_buf[tx_idx][3:0];
        tx_byte   = (reply_hex && !tx_idx[1]) ? hex_char : reply_buf[tx_idx];
    end

    // Parse-state update for a non-terminator byte
    always_comb begin
        ps_nxt = ps;
        if (!ps.active) begin
            ps_nxt.active = 1'b1;
            if (rx_fifo_data_out == ASCII_R || rx_fifo_data_out == ASCII_LR) begin
                ps_nxt.cmd = CMD_READ;
            end else if (rx_fifo_data_out == ASCII_W || rx_fifo_data_out == ASCII_LW) begin
                ps_nxt.cmd = CMD_WRITE;
            end else begin
                ps_nxt.err = 1'b1;
            end
        end else if (!ps.err) begin
            if (digit_valid) begin
                ps_nxt.acc       = {ps.acc[11:0], digit_val};
                ps_nxt.digit_cnt = (ps.digit_cnt == 3'd7) ? 3'd7 : ps.digit_cnt + 3'd1;
            end else begin
                ps_nxt.err = 1'b1;
            end
        end
    end

    // Main FSM: pop, decode, execute, and stream the reply
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            ps              <= '0;
            reply_hex       <= 1'b0;
            tx_idx          <= 2'd0;
            rx_fifo_read_en <= 1'b0;
            start_uart_tx   <= 1'b0;
            uart_tx_data    <= 8'h00;
            reg_wr_pulse    <= 1'b0;
            reg_wr_addr     <= 8'h00;
            busy            <= 1'b0;
            for (int unsigned i = 0; i < REPLY_LEN; i++) reply_buf[i] <= 8'h00;
            for (int unsigned i = 0; i < NUM_REGS; i++)  regs_q[i]    <= REG_RESET;
        end else begin
            rx_fifo_read_en <= 1'b0;
            start_uart_tx   <= 1'b0;
            reg_wr_pulse    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_fifo_empty) begin
                        rx_fifo_read_en <= 1'b1;
                        state           <= ST_WAIT;
                        busy            <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (!is_term(rx_fifo_data_out)) begin
                        ps    <= ps_nxt;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (!ps.active) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        reply_buf[2] <= ASCII_CR;
                        reply_buf[3] <= ASCII_LF;
                        tx_idx       <= 2'd0;
                        state        <= ST_TX;
                        if (line_err) begin
                            reply_buf[0] <= ASCII_E;
                            reply_buf[1] <= ASCII_R;
                            reply_hex    <= 1'b0;
                        end else if (ps.cmd == CMD_WRITE) begin
                            regs_q[AW'(exec_addr)] <= ps.acc[7:0];
                            reg_wr_pulse           <= 1'b1;
                            reg_wr_addr            <= exec_addr;
                            reply_buf[0]           <= ASCII_O;
                            reply_buf[1]           <= ASCII_K;
                            reply_hex              <= 1'b0;
                        end else begin
                            reply_buf[0] <= {4'h0, rd_val[7:4]};
                            reply_buf[1] <= {4'h0, rd_val[3:0]};
                            reply_hex    <= 1'b1;
                        end
                    end
                end
                ST_TX: begin
                    if (uart_tx_fifo_ready) begin
                        start_uart_tx <= 1'b1;
                        uart_tx_data  <= tx_byte;
                        if (tx_idx == 2'd3) begin
                            ps    <= '0;
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            tx_idx <= tx_idx + 2'd1;
                            state  <= ST_TXGAP;
                        end
                    end
                end
                ST_TXGAP: begin
                    state <= ST_TX;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed plus randomized bench for uart_cmd_responder with a line-level reference model.
module tb_uart_cmd_responder;

    localparam int unsigned NREG    = 16;
    localparam logic [7:0]  RST_VAL = 8'h00;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                rx_fifo_empty = 1'b1;
    logic [7:0]          rx_fifo_data_out = 8'h00;
    logic                rx_fifo_read_en;
    logic                uart_tx_fifo_ready = 1'b1;
    logic                start_uart_tx;
    logic [7:0]          uart_tx_data;
    logic [8*NREG-1:0]   regs_flat;
    logic                reg_wr_pulse;
    logic [7:0]          reg_wr_addr;
    logic                busy;

    always #5 clk = ~clk;

    uart_cmd_responder #(.NUM_REGS(NREG), .REG_RESET(RST_VAL)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .rx_fifo_empty      (rx_fifo_empty),
        .rx_fifo_data_out   (rx_fifo_data_out),
        .rx_fifo_read_en    (rx_fifo_read_en),
        .uart_tx_fifo_ready (uart_tx_fifo_ready),
        .start_uart_tx      (start_uart_tx),
        .uart_tx_data       (uart_tx_data),
        .regs_flat          (regs_flat),
        .reg_wr_pulse       (reg_wr_pulse),
        .reg_wr_addr        (reg_wr_addr),
        .busy               (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pop_err = 0;
    int gap_err = 0;
    int wr_cnt  = 0;
    int exp_wr_cnt = 0;
    logic [7:0] exp_wr_addr = 8'h00;
    int got_ptr = 0;
    int hold_mode = 0;
    logic tx_hold = 1'b0;
    logic prev_start = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

    byte unsigned rxq[$];
    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    byte unsigned line_q[$];
    logic [7:0]   m_regs [NREG];
    string        hexs = "0123456789ABCDEF";

    // RX FIFO: registered head data, empty flag updated at each edge
    always @(posedge clk) begin
        if (rx_fifo_read_en) begin
            if (rx_fifo_empty || rxq.size() == 0) pop_err++;
            else rx_fifo_data_out <= rxq.pop_front();
        end
        rx_fifo_empty <= (rxq.size() == 0);
    end

    // TX FIFO ready flag, registered from the hold request
    always @(posedge clk) uart_tx_fifo_ready <= !tx_hold;

    always @(negedge clk) tx_hold <= (hold_mode == 1) || (hold_mode == 2 && $urandom_range(0, 2) == 0);

    // Capture enqueued bytes and watch strobe widths
    always @(negedge clk) begin
        if (start_uart_tx) got_q.push_back(uart_tx_data);
        if (reg_wr_pulse) wr_cnt++;
        if (start_uart_tx && prev_start) gap_err++;
        if (reg_wr_pulse && prev_wr) gap_err++;
        if (rx_fifo_read_en && prev_rd) gap_err++;
        prev_start = start_uart_tx;
        prev_wr    = reg_wr_pulse;
        prev_rd    = rx_fifo_read_en;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int hexv(input byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    // Reference: evaluate one complete non-empty line
    task automatic m_eval();
        byte unsigned c = line_q[0];
        int nd = line_q.size() - 1;
        bit ok = 1'b1;
        int val = 0;
        for (int i = 1; i < line_q.size(); i++) begin
            int h = hexv(line_q[i]);
            if (h < 0) ok = 1'b0;
            else val = (val << 4) | h;
        end
        if ((c == "R" || c == "r") && ok && nd == 2 && val < NREG) begin
            exp_q.push_back(hexs[m_regs[val][7:4]]);
            exp_q.push_back(hexs[m_regs[val][3:0]]);
        end else if ((c == "W" || c == "w") && ok && nd == 4 && (val >> 8) < NREG) begin
            m_regs[val >> 8] = 8'(val);
            exp_wr_cnt++;
            exp_wr_addr = 8'(val >> 8);
            exp_q.push_back("O");
            exp_q.push_back("K");
        end else begin
            exp_q.push_back("E");
            exp_q.push_back("R");
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic m_push(input byte unsigned b);
        rxq.push_back(b);
        if (b == 8'h0D || b == 8'h0A) begin
            if (line_q.size() > 0) m_eval();
            line_q.delete();
        end else begin
            line_q.push_back(b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) m_push(s[i]);
    endtask

    task automatic push_hex(input int n, input bit lc);
        if (n < 10) m_push(8'(48 + n));
        else m_push(8'((lc ? 87 : 55) + n));
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = RST_VAL;
        line_q.delete();
        exp_q.delete();
        exp_wr_addr = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        got_ptr = got_q.size();
    endtask

    task automatic drain();
        int idle = 0;
        int cyc = 0;
        while (idle < 4 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (rxq.size() == 0 && !busy) idle++;
            else idle = 0;
        end
        chk("drain_done", int'(idle >= 4), 1);
    endtask

    task automatic wait_strobe();
        int base = got_q.size();
        int cyc = 0;
        while (got_q.size() == base && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("strobe_seen", int'(got_q.size() > base), 1);
    endtask

    task automatic check_all(input string tag);
        logic [8*NREG-1:0] mf;
        int n = got_q.size() - got_ptr;
        chk({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk({tag, "_byte"}, got_q[got_ptr + i], exp_q[i]);
        got_ptr = got_q.size();
        exp_q.delete();
        for (int i = 0; i < NREG; i++) mf[8*i +: 8] = m_regs[i];
        n_tests++;
        assert (regs_flat === mf) else begin
            n_fail++;
            $error("FAIL %s_regs: observed %0h expected %0h", tag, regs_flat, mf);
        end
        chk({tag, "_wr_cnt"}, wr_cnt, exp_wr_cnt);
        chk({tag, "_wr_addr"}, reg_wr_addr, exp_wr_addr);
    endtask

    task automatic rand_cmd();
        int k = $urandom_range(0, 6);
        bit lc = 1'($urandom_range(0, 1));
        int a;
        int d;
        int bad;
        int nd;
        if ($urandom_range(0, 4) == 0) m_push(8'h0A);
        case (k)
            0: begin
                m_push(lc ? "r" : "R");
                a = $urandom_range(0, NREG - 1);
                push_hex(a >> 4, lc); push_hex(a & 15, lc);
            end
            1, 2: begin
                m_push(lc ? "w" : "W");
                a = (k == 1) ? $urandom_range(0, NREG - 1) : $urandom_range(NREG, 255);
                d = $urandom_range(0, 255);
                push_hex(a >> 4, lc); push_hex(a & 15, lc);
                push_hex(d >> 4, lc); push_hex(d & 15, lc);
            end
            3: begin
                m_push("R");
                a = $urandom_range(NREG, 255);
                push_hex(a >> 4, lc); push_hex(a & 15, lc);
            end
            4: begin
                m_push("W");
                bad = $urandom_range(0, 3);
                for (int i = 0; i < 4; i++) begin
                    if (i == bad) m_push(8'(71 + $urandom_range(0, 19)));
                    else push_hex($urandom_range(0, 15), lc);
                end
            end
            5: begin
                m_push(lc ? "r" : "W");
                nd = $urandom_range(0, 1) ? $urandom_range(5, 7) : $urandom_range(0, 1);
                for (int i = 0; i < nd; i++) push_hex($urandom_range(0, 15), lc);
            end
            default: begin
                m_push("X");
                push_hex($urandom_range(0, 15), lc); push_hex($urandom_range(0, 15), lc);
            end
        endcase
        case ($urandom_range(0, 2))
            0: m_push(8'h0D);
            1: m_push(8'h0A);
            default: begin m_push(8'h0D); m_push(8'h0A); end
        endcase
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rx_fifo_read_en, 0);
        chk("rst_start", start_uart_tx, 0);
        chk("rst_tx_data", uart_tx_data, 0);
        chk("rst_wr_pulse", reg_wr_pulse, 0);
        chk("rst_wr_addr", reg_wr_addr, 0);
        reset_n = 1'b1;
        check_all("reset");

        send_str("W053C\r");
        drain();
        check_all("write");
        chk("reg5", regs_flat[47:40], 8'h3C);

        send_str("r05\n");
        drain();
        check_all("read");

        send_str("R10\r");
        drain();
        check_all("bad_addr");

        send_str("WZZ12\r");
        send_str("W1234567\r");
        drain();
        check_all("malformed");

        send_str("R00\r\n\r\n");
        drain();
        check_all("blank");

        send_str("R05\r");
        wait_strobe();
        hold_mode = 1;
        repeat (50) @(negedge clk);
        hold_mode = 0;
        drain();
        check_all("backpressure");

        send_str("W0");
        drain();
        pulse_reset();
        send_str("W0A55\r");
        wait_strobe();
        pulse_reset();
        send_str("R00\r");
        drain();
        check_all("post_reset");

        hold_mode = 2;
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 6; c++) rand_cmd();
            drain();
            check_all("random");
        end
        hold_mode = 0;
        repeat (4) @(negedge clk);

        chk("protocol", pop_err + gap_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
